// File: rtl/softmax_host_buffer_if.sv
// ---------------------------------------------------------------------------
// softmax_host_buffer_if
// Link between the host buffer and one softmax core.
//   sm_init / sm_start          : job handshake to the core
//   sm_start_addr / sm_end_addr : word range of the current job
//   rd0..rd2 addr/data          : three zero-latency read ports (max, sub0, sub1)
//   res_valid / res_data        : result word stream from the core
//   res_done                    : core finished the job
// Modports: master = buffer side, slave = core side.
// ---------------------------------------------------------------------------
interface softmax_host_buffer_if #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8
);
  logic                          sm_init;
  logic                          sm_start;
  logic [ADDRSIZE-1:0]           sm_start_addr;
  logic [ADDRSIZE-1:0]           sm_end_addr;
  logic [ADDRSIZE-1:0]           rd0_addr;
  logic [ADDRSIZE-1:0]           rd1_addr;
  logic [ADDRSIZE-1:0]           rd2_addr;
  logic [DATAWIDTH*NUM-1:0]      rd0_data;
  logic [DATAWIDTH*NUM-1:0]      rd1_data;
  logic [DATAWIDTH*NUM-1:0]      rd2_data;
  logic                          res_valid;
  logic [DATAWIDTH*NUM-1:0]      res_data;
  logic                          res_done;

  modport master (
    output sm_init, sm_start, sm_start_addr, sm_end_addr,
    output rd0_data, rd1_data, rd2_data,
    input  rd0_addr, rd1_addr, rd2_addr,
    input  res_valid, res_data, res_done
  );

  modport slave (
    input  sm_init, sm_start, sm_start_addr, sm_end_addr,
    input  rd0_data, rd1_data, rd2_data,
    output rd0_addr, rd1_addr, rd2_addr,
    output res_valid, res_data, res_done
  );
endinterface

// File: rtl/softmax_host_buffer.sv
// ---------------------------------------------------------------------------
// softmax_host_buffer
// Memory-side counterpart of the softmax core. Holds input vectors, serves the
// core's three read ports combinationally, sequences init/start, captures the
// result stream and reports completion to the host.
// Ports:
//   clk, reset                  : clock, synchronous active-low reset
//   ld_we/ld_addr/ld_data       : host load into the input buffer
//   ld_reject                   : pulse, load dropped because busy
//   job_go/job_start_addr/
//   job_end_addr                : job launch (end is one past last word)
//   busy, job_done, err,
//   res_count                   : job status
//   core                        : master side of the core link
//   rb_addr/rb_data             : host readback of the result buffer
// ---------------------------------------------------------------------------
module softmax_host_buffer #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_we,
  input  logic [ADDRSIZE-1:0]      ld_addr,
  input  logic [DATAWIDTH*NUM-1:0] ld_data,
  output logic                     ld_reject,
  input  logic                     job_go,
  input  logic [ADDRSIZE-1:0]      job_start_addr,
  input  logic [ADDRSIZE-1:0]      job_end_addr,
  output logic                     busy,
  output logic                     job_done,
  output logic                     err,
  output logic [ADDRSIZE-1:0]      res_count,
  softmax_host_buffer_if.master    core,
  input  logic [ADDRSIZE-1:0]      rb_addr,
  output logic [DATAWIDTH*NUM-1:0] rb_data
);
  localparam int WW    = DATAWIDTH * NUM;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int WDW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_START, S_RUN, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [WW-1:0]       inbuf  [DEPTH];
  logic [WW-1:0]       resbuf [DEPTH];
  logic [ADDRSIZE-1:0] ptr_q;
  logic [ADDRSIZE-1:0] start_q, end_q;
  logic [WDW-1:0]      wd_q;

  logic job_ok, job_bad, wd_expired, res_wr, res_ovf;

  assign job_ok     = job_go && (job_end_addr > job_start_addr);
  assign job_bad    = job_go && !(job_end_addr > job_start_addr);
  assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));
  // A result arriving with the pointer already at the end address overflows.
  assign res_wr     = (state_q == S_RUN) && core.res_valid && (ptr_q != end_q);
  assign res_ovf    = (state_q == S_RUN) && core.res_valid && (ptr_q == end_q);

  // Zero-latency reads: the core samples data in the cycle it drives the address.
  assign core.rd0_data      = inbuf[core.rd0_addr];
  assign core.rd1_data      = inbuf[core.rd1_addr];
  assign core.rd2_data      = inbuf[core.rd2_addr];
  assign rb_data            = resbuf[rb_addr];
  assign core.sm_start_addr = start_q;
  assign core.sm_end_addr   = end_q;

  // NOTE: buffers carry no reset; contents survive reset and a RAM macro can be used.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) inbuf[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset && res_wr) resbuf[ptr_q] <= core.res_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    busy          = 1'b1;
    core.sm_init  = 1'b0;
    core.sm_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (job_ok) state_d = S_INIT;
      end
      S_INIT: begin
        core.sm_init = 1'b1;
        state_d      = S_START;
      end
      S_START: begin
        core.sm_start = 1'b1;
        state_d       = S_RUN;
      end
      S_RUN:    if (core.res_done || wd_expired) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_reject <= 1'b0;
      job_done  <= 1'b0;
      err       <= 1'b0;
      res_count <= '0;
      start_q   <= '0;
      end_q     <= '0;
      ptr_q     <= '0;
      wd_q      <= '0;
    end else begin
      ld_reject <= ld_we && busy;
      // Pulse for a rejected empty job, or while the FSM sits in FINISH.
      job_done  <= ((state_q == S_IDLE) && job_bad) ||
                   ((state_q == S_RUN) && (state_d == S_FINISH));
      case (state_q)
        S_IDLE: begin
          if (job_ok) begin
            start_q   <= job_start_addr;
            end_q     <= job_end_addr;
            ptr_q     <= job_start_addr;
            res_count <= '0;
            err       <= 1'b0;
          end else if (job_bad) begin
            err <= 1'b1;
          end
        end
        S_START: wd_q <= '0;
        S_RUN: begin
          wd_q <= wd_q + WDW'(1);
          if (res_wr) begin
            ptr_q     <= ptr_q + ADDRSIZE'(1);
            res_count <= res_count + ADDRSIZE'(1);
          end
          if (res_ovf || wd_expired) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
